dm_result_reader: RTL and testbench

DM_RESULT_READER -- requirements
Module: dm_result_reader

---
 rtl/dm_result_reader.sv | 132 +++++++++++++
 tb/tb_dm_result_reader.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dm_result_reader.sv
// dm_result_reader: waits for the end-of-simulation code to be written to a
// watched DM word, then reads NUM_WORDS result words out of DM and streams
// them on a valid/ready port, followed by the 64-bit cycle count that was
// frozen at the moment the end code was seen.
module dm_result_reader #(
  parameter int                ADDR_W     = 14,
  parameter logic [ADDR_W-1:0] END_ADDR   = 14'h3fff,
  parameter logic [31:0]       END_CODE   = 32'hffffffff,
  parameter logic [ADDR_W-1:0] START_ADDR = 14'h2000,
  parameter int                NUM_WORDS  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              snoop_we,
  input  logic [ADDR_W-1:0] snoop_addr,
  input  logic [31:0]       snoop_wdata,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  output logic              m_valid,
  output logic [31:0]       m_data,
  output logic              m_last,
  input  logic              m_ready,
  output logic              busy,
  output logic              done
);

  localparam int               IDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_OUT, S_DONE} state_t;

  // which word OUT is presenting: DM result, counter low half, counter high half
  typedef enum logic [1:0] {W_RES, W_CLO, W_CHI} wsel_t;

  state_t           state, state_nxt;
  wsel_t            wsel, wsel_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [31:0]      data_q, data_nxt;
  logic             last_q, last_nxt;
  logic [63:0]      cnt;
  logic             frozen;
  logic             trig;

  assign trig = snoop_we && (snoop_addr == END_ADDR) && (snoop_wdata == END_CODE);

  // cycle counter: runs from reset until the accepted trigger edge, then holds
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt    <= '0;
      frozen <= 1'b0;
    end else if (!frozen) begin
      if (state == S_IDLE && trig) frozen <= 1'b1;
      else                         cnt    <= cnt + 64'd1;
    end
  end

  // state and output-data registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= S_IDLE;
      wsel   <= W_RES;
      idx    <= '0;
      data_q <= '0;
      last_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      wsel   <= wsel_nxt;
      idx    <= idx_nxt;
      data_q <= data_nxt;
      last_q <= last_nxt;
    end
  end

  // sequencing: one DM read per result word, counter words straight from cnt
  always_comb begin
    state_nxt = state;
    wsel_nxt  = wsel;
    idx_nxt   = idx;
    data_nxt  = data_q;
    last_nxt  = last_q;
    case (state)
      S_IDLE: begin
        if (trig) begin
          state_nxt = S_REQ;
          wsel_nxt  = W_RES;
          idx_nxt   = '0;
          last_nxt  = 1'b0;
        end
      end
      S_REQ:  state_nxt = S_WAIT;
      S_WAIT: begin
        data_nxt  = rd_data;
        state_nxt = S_OUT;
      end
      S_OUT: begin
        if (m_ready) begin
          case (wsel)
            W_RES: begin
              if (idx != LAST_IDX) begin
                idx_nxt   = idx + IDX_W'(1);
                state_nxt = S_REQ;
              end else begin
                data_nxt = cnt[31:0];
                wsel_nxt = W_CLO;
              end
            end
            W_CLO: begin
              data_nxt = cnt[63:32];
              last_nxt = 1'b1;
              wsel_nxt = W_CHI;
            end
            default: begin
              last_nxt  = 1'b0;
              state_nxt = S_DONE;
            end
          endcase
        end
      end
      default: state_nxt = S_DONE;
    endcase
  end

  assign rd_req  = (state == S_REQ);
  assign rd_addr = (state == S_REQ) ? START_ADDR + ADDR_W'(idx) : '0;
  assign m_valid = (state == S_OUT);
  assign m_data  = data_q;
  assign m_last  = last_q;
  assign busy    = (state == S_REQ) || (state == S_WAIT) || (state == S_OUT);
  assign done    = (state == S_DONE);

endmodule

// File: tb/tb_dm_result_reader.sv
// Bench for dm_result_reader: a queue-based model of the expected word stream
// and timing, checked every falling edge, plus literal expected sequences.
module tb_dm_result_reader;
  localparam int          NW = 4;
  localparam logic [13:0] SA = 14'h2000;

  logic        clk = 1'b0, rst = 1'b0, snoop_we = 1'b0, m_ready = 1'b1;
  logic [13:0] snoop_addr = '0;
  logic [31:0] snoop_wdata = '0, rd_data = '0, w_rd_data = '0;
  logic        rd_req, m_valid, m_last, busy, done;
  logic [13:0] rd_addr;
  logic [31:0] m_data;
  logic        w_rd_req, w_m_valid, w_m_last, w_busy, w_done;
  logic [13:0] w_rd_addr;
  logic [31:0] w_m_data;

  dm_result_reader #(.NUM_WORDS(NW)) u_dut (
    .clk(clk), .rst(rst), .snoop_we(snoop_we), .snoop_addr(snoop_addr),
    .snoop_wdata(snoop_wdata), .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .busy(busy), .done(done));

  dm_result_reader #(.START_ADDR(14'h3ffe), .NUM_WORDS(NW)) u_wrap (
    .clk(clk), .rst(rst), .snoop_we(snoop_we), .snoop_addr(snoop_addr),
    .snoop_wdata(snoop_wdata), .rd_req(w_rd_req), .rd_addr(w_rd_addr), .rd_data(w_rd_data),
    .m_valid(w_m_valid), .m_data(w_m_data), .m_last(w_m_last), .m_ready(m_ready),
    .busy(w_busy), .done(w_done));

  always #5 clk = ~clk;

  // DM contents: DM[0x2000+i] = i + 0x100
  function automatic logic [31:0] dm(input logic [13:0] a);
    logic [13:0] o;
    o = a - 14'h2000;
    return 32'(o) + 32'h100;
  endfunction

  // DM read port: data one cycle after the request
  always @(posedge clk) begin
    if (rd_req)   rd_data   <= dm(rd_addr);
    if (w_rd_req) w_rd_data <= dm(w_rd_addr);
  end

  int          n_vec = 0, n_bad = 0;
  logic [63:0] cyc = '0;
  bit          frozen = 0, active = 0, dn = 0, fresh = 1;
  int          gap = 0, nreq = 0, chk_ack = 0;
  logic [31:0] q[$];
  logic [31:0] acc_log[$];
  logic [13:0] waddr[$];

  // handshake from the stimulus to the checker
  int          chk_req = 0, chk_kind = 0, log_base = 0, req_base = 0, wbase = 0;
  logic [31:0] lit[6];

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // checker + model: outputs are compared on the falling edge, then the model
  // advances by what the next rising edge will do with the current inputs
  always @(negedge clk) begin
    bit ev, erq, trig, fire;
    logic [31:0] w;
    ev  = active && gap == 0 && q.size() > 0;
    erq = active && gap == 2 && q.size() > 2;
    cmp("m_valid", 64'(m_valid), 64'(ev));
    cmp("busy",    64'(busy),    64'(active));
    cmp("done",    64'(done),    64'(dn));
    cmp("m_last",  64'(m_last),  64'(ev && q.size() == 1));
    cmp("rd_req",  64'(rd_req),  64'(erq));
    if (ev)  cmp("m_data", 64'(m_data), 64'(q[0]));
    if (erq) cmp("rd_addr", 64'(rd_addr), 64'(SA + 14'(NW + 2 - q.size())));
    if (fresh && !active) begin
      cmp("m_data_idle",  64'(m_data),  64'd0);
      cmp("rd_addr_idle", 64'(rd_addr), 64'd0);
    end
    if (m_valid && m_ready) acc_log.push_back(m_data);
    if (rd_req) nreq++;
    if (w_rd_req) waddr.push_back(w_rd_addr);

    if (chk_req != chk_ack) begin
      chk_ack = chk_req;
      case (chk_kind)
        1: begin
          cmp("stream_len", 64'(acc_log.size() - log_base), 64'd6);
          for (int j = 0; j < 6; j++) begin
            w = (log_base + j < acc_log.size()) ? acc_log[log_base + j] : 32'hxxxxxxxx;
            cmp($sformatf("word%0d", j), 64'(w), 64'(lit[j]));
          end
          cmp("rd_req_pulses", 64'(nreq - req_base), 64'(NW));
        end
        2: begin
          cmp("wrap_reads", 64'(waddr.size() - wbase), 64'(NW));
          for (int j = 0; j < NW; j++) begin
            w = (wbase + j < waddr.size()) ? 32'(waddr[wbase + j]) : 32'hxxxxxxxx;
            cmp($sformatf("wrap_addr%0d", j), 64'(w), 64'(lit[j]));
          end
        end
        3: begin
          cmp("no_rd_req", 64'(nreq - req_base), 64'd0);
          cmp("not_busy",  64'(busy), 64'd0);
        end
        default: cmp("done_within_budget", 64'(done), 64'd1);
      endcase
    end

    if (!rst) begin
      cyc = '0; frozen = 0; active = 0; dn = 0; fresh = 1; gap = 0;
      q.delete();
    end else begin
      trig = snoop_we && snoop_addr == 14'h3fff && snoop_wdata == 32'hffffffff;
      fire = 0;
      if (active) begin
        if (gap > 0) gap--;
        else if (m_ready) begin
          void'(q.pop_front());
          if (q.size() == 0) begin active = 0; dn = 1; end
          else gap = (q.size() > 2) ? 2 : 0;
        end
      end else if (!dn && trig) begin
        fire = 1; active = 1; fresh = 0; gap = 2;
        for (int i = 0; i < NW; i++) q.push_back(dm(SA + 14'(i)));
        q.push_back(cyc[31:0]);
        q.push_back(cyc[63:32]);
      end
      if (!frozen) begin
        if (fire) frozen = 1;
        else      cyc = cyc + 64'd1;
      end
    end
  end

  task automatic post(input int k);
    chk_kind = k;
    chk_req++;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic write(input logic [13:0] a, input logic [31:0] d);
    snoop_we = 1'b1; snoop_addr = a; snoop_wdata = d;
    @(posedge clk); #1;
    snoop_we = 1'b0; snoop_addr = '0; snoop_wdata = '0;
  endtask

  // n cycles after reset release, the end code lands on the edge where count = n
  task automatic start_run(input int n);
    repeat (n) @(posedge clk);
    #1 write(14'h3fff, 32'hffffffff);
  endtask

  task automatic wait_done(input int max, input bit tog, input bit extra);
    for (int i = 0; i < max; i++) begin
      if (done) break;
      @(posedge clk); #1;
      if (tog) m_ready = ~m_ready;
      if (extra && i == 4) begin
        snoop_we = 1'b1; snoop_addr = 14'h3fff; snoop_wdata = 32'hffffffff;
      end
      if (extra && i == 5) snoop_we = 1'b0;
    end
    snoop_we = 1'b0;
    m_ready  = 1'b1;
    post(4);
  endtask

  task automatic set_lit(input logic [31:0] a, b, c, d, e, f);
    lit[0] = a; lit[1] = b; lit[2] = c; lit[3] = d; lit[4] = e; lit[5] = f;
  endtask

  initial begin
    // reset, then a plain run with the sink always ready
    do_reset();
    log_base = acc_log.size(); req_base = nreq; wbase = waddr.size();
    start_run(50);
    wait_done(200, 0, 0);
    set_lit(32'h100, 32'h101, 32'h102, 32'h103, 32'd50, 32'd0);
    post(1);
    set_lit(32'h3ffe, 32'h3fff, 32'h0000, 32'h0001, 32'd0, 32'd0);
    post(2);

    // near-miss writes must not start anything
    do_reset();
    req_base = nreq;
    write(14'h3fff, 32'h00000001);
    write(14'h3ffe, 32'hffffffff);
    repeat (10) @(posedge clk);
    #1 post(3);

    // backpressure toggling, a repeat trigger mid-stream and one after done
    do_reset();
    log_base = acc_log.size(); req_base = nreq;
    start_run(50);
    wait_done(300, 1, 1);
    write(14'h3fff, 32'hffffffff);
    repeat (8) @(posedge clk);
    #1 set_lit(32'h100, 32'h101, 32'h102, 32'h103, 32'd50, 32'd0);
    post(1);

    // reset while the third word is waiting, then a fresh run
    do_reset();
    start_run(20);
    for (int i = 0; i < 100; i++) begin
      if (m_valid && acc_log.size() - log_base >= 2) break;
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    log_base = acc_log.size(); req_base = nreq;
    start_run(30);
    wait_done(200, 0, 0);
    set_lit(32'h100, 32'h101, 32'h102, 32'h103, 32'd30, 32'd0);
    post(1);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
